decoder_10b8b: RTL and testbench

Receive-side 8b/10b decoder for the PCIe physical layer, the inverse of the transmit-side 3b/4b + 5b/6b encode path. It takes one 10-bit symbol per qualified cycle and produces:
- the decoded byte and K-flag;
- code-violation and running-disparity error flags;
- a tracked running disparity;
- a symbol-lock state machine driven by COM (K28.5) reception and consecutive-error counting.

It sits between the deserializer/aligner and the lane descrambler.

---
 rtl/pcie_8b10b_pkg.sv | 128 ++++++++++++
 rtl/decoder_4b3b.sv | 32 +++
 rtl/decoder_10b8b.sv | 138 +++++++++++++
 tb/tb_decoder_10b8b.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b decode types, symbol constants and sub-block helpers used by
// the receive-side decoder.
package pcie_8b10b_pkg;

   localparam logic [9:0] K28_5_RDN  = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP  = 10'b1100000101;
   localparam logic [7:0] K28_5_BYTE = 8'hBC;
   localparam logic [7:0] K28_1_BYTE = 8'h3C;
   localparam logic [7:0] D21_5_BYTE = 8'hB5;
   localparam logic [5:0] K28_6B_RDN = 6'b001111;
   localparam logic [5:0] K28_6B_RDP = 6'b110000;

   typedef enum logic {
      LOCK_UNLOCKED = 1'b0,
      LOCK_LOCKED   = 1'b1
   } lock_state_e;

   // HOLD_* are the balanced-but-skewed sub-blocks 000111/0011 and 111000/1100.
   typedef enum logic [2:0] {
      DISP_NEUTRAL,
      DISP_POS,
      DISP_NEG,
      DISP_HOLD_POS,
      DISP_HOLD_NEG
   } disp_e;

   typedef struct packed {
      logic [4:0] data;
      logic       valid;
      logic       k28;
      logic       k_ok;
      logic       a7_ok;
      disp_e      disp;
   } dec6_t;

   function automatic disp_e disp_of(input logic hold_pos, input logic hold_neg,
                                     input int ones, input int half);
      disp_e d;
      if (hold_pos)         d = DISP_HOLD_POS;
      else if (hold_neg)    d = DISP_HOLD_NEG;
      else if (ones > half) d = DISP_POS;
      else if (ones < half) d = DISP_NEG;
      else                  d = DISP_NEUTRAL;
      return d;
   endfunction

   function automatic disp_e disp_invert(input disp_e d);
      disp_e r;
      case (d)
         DISP_POS:      r = DISP_NEG;
         DISP_NEG:      r = DISP_POS;
         DISP_HOLD_POS: r = DISP_HOLD_NEG;
         DISP_HOLD_NEG: r = DISP_HOLD_POS;
         default:       r = DISP_NEUTRAL;
      endcase
      return r;
   endfunction

   function automatic logic disp_illegal(input disp_e d, input logic rd_neg);
      logic bad;
      case (d)
         DISP_POS, DISP_HOLD_NEG: bad = !rd_neg;
         DISP_NEG, DISP_HOLD_POS: bad = rd_neg;
         default:                 bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic rd_after(input disp_e d, input logic rd_neg);
      logic r;
      case (d)
         DISP_POS, DISP_HOLD_POS: r = 1'b0;
         DISP_NEG, DISP_HOLD_NEG: r = 1'b1;
         default:                 r = rd_neg;
      endcase
      return r;
   endfunction

   // abcdei -> EDCBA; disparity class comes from the raw bits so it is valid
   // even for undefined codes.
   function automatic dec6_t dec_6b(input logic [5:0] abcdei);
      dec6_t r;
      r.data  = 5'd0;
      r.valid = 1'b1;
      r.k28   = 1'b0;
      r.k_ok  = 1'b0;
      r.a7_ok = 1'b0;
      r.disp  = disp_of(abcdei == 6'b000111, abcdei == 6'b111000, $countones(abcdei), 3);
      case (abcdei)
         6'b100111, 6'b011000: r.data = 5'd0;
         6'b011101, 6'b100010: r.data = 5'd1;
         6'b101101, 6'b010010: r.data = 5'd2;
         6'b110001:            r.data = 5'd3;
         6'b110101, 6'b001010: r.data = 5'd4;
         6'b101001:            r.data = 5'd5;
         6'b011001:            r.data = 5'd6;
         6'b111000, 6'b000111: r.data = 5'd7;
         6'b111001, 6'b000110: r.data = 5'd8;
         6'b100101:            r.data = 5'd9;
         6'b010101:            r.data = 5'd10;
         6'b110100:            begin r.data = 5'd11; r.a7_ok = 1'b1; end
         6'b001101:            r.data = 5'd12;
         6'b101100:            begin r.data = 5'd13; r.a7_ok = 1'b1; end
         6'b011100:            begin r.data = 5'd14; r.a7_ok = 1'b1; end
         6'b010111, 6'b101000: r.data = 5'd15;
         6'b011011, 6'b100100: r.data = 5'd16;
         6'b100011:            begin r.data = 5'd17; r.a7_ok = 1'b1; end
         6'b010011:            begin r.data = 5'd18; r.a7_ok = 1'b1; end
         6'b110010:            r.data = 5'd19;
         6'b001011:            begin r.data = 5'd20; r.a7_ok = 1'b1; end
         6'b101010:            r.data = 5'd21;
         6'b011010:            r.data = 5'd22;
         6'b111010, 6'b000101: begin r.data = 5'd23; r.k_ok = 1'b1; end
         6'b110011, 6'b001100: r.data = 5'd24;
         6'b100110:            r.data = 5'd25;
         6'b010110:            r.data = 5'd26;
         6'b110110, 6'b001001: begin r.data = 5'd27; r.k_ok = 1'b1; end
         6'b001110:            r.data = 5'd28;
         K28_6B_RDN, K28_6B_RDP: begin r.data = 5'd28; r.k28 = 1'b1; end
         6'b101110, 6'b010001: begin r.data = 5'd29; r.k_ok = 1'b1; end
         6'b011110, 6'b100001: begin r.data = 5'd30; r.k_ok = 1'b1; end
         6'b101011, 6'b010100: r.data = 5'd31;
         default:              r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decoder_4b3b.sv
// Combinational fghj -> HGF decode with validity, alternate-7 flag and
// disparity class of the 4-bit sub-block.
module decoder_4b3b
   import pcie_8b10b_pkg::*;
(
   input  logic [3:0] fghj,
   output logic [2:0] hgf,
   output logic       valid,
   output logic       k_form,
   output disp_e      disp
);

   always_comb begin
      hgf    = 3'd0;
      valid  = 1'b1;
      k_form = 1'b0;
      case (fghj)
         4'b0100, 4'b1011: hgf = 3'd0;
         4'b1001:          hgf = 3'd1;
         4'b0101:          hgf = 3'd2;
         4'b0011, 4'b1100: hgf = 3'd3;
         4'b0010, 4'b1101: hgf = 3'd4;
         4'b1010:          hgf = 3'd5;
         4'b0110:          hgf = 3'd6;
         4'b0001, 4'b1110: hgf = 3'd7;
         4'b1000, 4'b0111: begin hgf = 3'd7; k_form = 1'b1; end
         default:          valid = 1'b0;
      endcase
      disp = disp_of(fghj == 4'b0011, fghj == 4'b1100, $countones(fghj), 2);
   end

endmodule

// File: rtl/decoder_10b8b.sv
// Receive-side 8b/10b decoder: symbol decode, running-disparity tracking,
// saturating error count and COM-driven symbol lock.
//
//   state         | meaning
//   LOCK_UNLOCKED | hunting for a clean K28.5
//   LOCK_LOCKED   | aligned; UNLOCK_ERRS consecutive errors drop lock
module decoder_10b8b
   import pcie_8b10b_pkg::*;
#(
   parameter int ERR_CNT_W   = 16,
   parameter int UNLOCK_ERRS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           symbol_in,
   input  logic                 symbol_valid,
   input  logic                 err_clear,
   output logic [7:0]           data_out,
   output logic                 is_k,
   output logic                 out_valid,
   output logic                 code_err,
   output logic                 disp_err,
   output logic                 run_disparity_neg,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int RUN_W = $clog2(UNLOCK_ERRS + 1);

   logic [5:0]       abcdei;
   logic [3:0]       fghj_dec;
   dec6_t            d6;
   logic             k28_rdp;
   logic [2:0]       hgf;
   logic             valid4;
   logic             k_form4;
   disp_e            disp4_dec;
   disp_e            disp4;
   logic             rd_mid_neg;
   logic             rd_end_neg;
   logic             code_err_c;
   logic             disp_err_c;
   logic             is_k_c;
   logic             sym_err;
   logic             com_clean;
   logic [7:0]       data_c;
   logic             rd_neg_q;
   lock_state_e      state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;

   assign abcdei  = symbol_in[9:4];
   assign d6      = dec_6b(abcdei);
   // K28.y from RD+ carries the complemented 4b form; undo it before decode.
   assign k28_rdp  = (abcdei == K28_6B_RDP);
   assign fghj_dec = k28_rdp ? ~symbol_in[3:0] : symbol_in[3:0];

   decoder_4b3b u_dec4 (
      .fghj   (fghj_dec),
      .hgf    (hgf),
      .valid  (valid4),
      .k_form (k_form4),
      .disp   (disp4_dec)
   );

   always_comb begin
      disp4      = k28_rdp ? disp_invert(disp4_dec) : disp4_dec;
      rd_mid_neg = rd_after(d6.disp, rd_neg_q);
      rd_end_neg = rd_after(disp4, rd_mid_neg);
      disp_err_c = disp_illegal(d6.disp, rd_neg_q) | disp_illegal(disp4, rd_mid_neg);
      code_err_c = !d6.valid || !valid4 || (k_form4 && !(d6.k28 || d6.k_ok || d6.a7_ok));
      is_k_c     = !code_err_c && (d6.k28 || (k_form4 && d6.k_ok));
      data_c     = code_err_c ? 8'h00 : {hgf, d6.data};
      sym_err    = symbol_valid && (code_err_c || disp_err_c);
      com_clean  = symbol_valid && is_k_c && !disp_err_c && (data_c == K28_5_BYTE);
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (symbol_valid) begin
         case (state_q)
            LOCK_UNLOCKED: begin
               run_d = '0;
               if (com_clean) state_d = LOCK_LOCKED;
            end
            LOCK_LOCKED: begin
               if (!sym_err) begin
                  run_d = '0;
               end else if (run_q == RUN_W'(UNLOCK_ERRS - 1)) begin
                  state_d = LOCK_UNLOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + RUN_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOCK_UNLOCKED;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out  <= 8'h00;
         is_k      <= 1'b0;
         out_valid <= 1'b0;
         code_err  <= 1'b0;
         disp_err  <= 1'b0;
         rd_neg_q  <= 1'b1;
         err_count <= '0;
      end else begin
         out_valid <= symbol_valid;
         if (symbol_valid) begin
            data_out <= data_c;
            is_k     <= is_k_c;
            code_err <= code_err_c;
            disp_err <= disp_err_c;
            rd_neg_q <= rd_end_neg;
         end
         if (err_clear)
            err_count <= '0;
         else if (sym_err && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
      end
   end

   assign run_disparity_neg = rd_neg_q;
   assign locked            = (state_q == LOCK_LOCKED);

endmodule

// File: tb/tb_decoder_10b8b.sv
// Scoreboard bench for decoder_10b8b: directed symbols push hand-derived
// expectations, a negedge monitor pops and compares on out_valid.
module tb_decoder_10b8b;

   localparam int CW = 4;
   localparam logic [9:0] S_K28_5N = 10'b0011111010;
   localparam logic [9:0] S_K28_5P = 10'b1100000101;
   localparam logic [9:0] S_D21_5  = 10'b1010101010;
   localparam logic [9:0] S_ZERO   = 10'b0000000000;

   logic          clk;
   logic          reset;
   logic [9:0]    symbol_in;
   logic          symbol_valid;
   logic          err_clear;
   logic [7:0]    data_out;
   logic          is_k;
   logic          out_valid;
   logic          code_err;
   logic          disp_err;
   logic          run_disparity_neg;
   logic          locked;
   logic [CW-1:0] err_count;

   typedef struct {
      int            id;
      logic [7:0]    data;
      logic          k;
      logic          ce;
      logic          de;
      logic          rdn;
      logic          lk;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_sent  = 0;

   decoder_10b8b #(.ERR_CNT_W(CW), .UNLOCK_ERRS(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .symbol_in         (symbol_in),
      .symbol_valid      (symbol_valid),
      .err_clear         (err_clear),
      .data_out          (data_out),
      .is_k              (is_k),
      .out_valid         (out_valid),
      .code_err          (code_err),
      .disp_err          (disp_err),
      .run_disparity_neg (run_disparity_neg),
      .locked            (locked),
      .err_count         (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic send(input logic [9:0] sym, input logic clr, input logic [7:0] d,
                       input logic k, input logic ce, input logic de, input logic rdn,
                       input logic lk, input logic [CW-1:0] cnt);
      exp_t e;
      @(negedge clk);
      symbol_in    = sym;
      symbol_valid = 1'b1;
      err_clear    = clr;
      e.id = n_sent; e.data = d; e.k = k; e.ce = ce; e.de = de;
      e.rdn = rdn; e.lk = lk; e.cnt = cnt;
      exp_q.push_back(e);
      n_sent++;
   endtask

   task automatic idle();
      @(negedge clk);
      symbol_valid = 1'b0;
      err_clear    = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: data=%h with no expected symbol pending", data_out);
         end else begin
            e = exp_q.pop_front();
            if (data_out !== e.data || is_k !== e.k || code_err !== e.ce || disp_err !== e.de ||
                run_disparity_neg !== e.rdn || locked !== e.lk || err_count !== e.cnt) begin
               n_fail++;
               $display("FAIL sym%0d: got data=%h k=%b ce=%b de=%b rdn=%b lk=%b cnt=%0d, expected data=%h k=%b ce=%b de=%b rdn=%b lk=%b cnt=%0d",
                        e.id, data_out, is_k, code_err, disp_err, run_disparity_neg, locked, err_count,
                        e.data, e.k, e.ce, e.de, e.rdn, e.lk, e.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b1;
      symbol_in    = '0;
      symbol_valid = 1'b0;
      err_clear    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rdn", 32'(run_disparity_neg), 32'd1);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      reset = 1'b0;

      //    symbol              clr  data   k     ce    de    rdn   lk    cnt
      send(S_K28_5N,            0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      send(S_D21_5,             0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      send(S_K28_5N,            0, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
      send(S_D21_5,             1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      send(10'b1100000110,      0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0); // K28.1 RD+
      send(10'b1110101000,      0, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0); // K23.7 RD-
      send(10'b1000110111,      0, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0); // D17.7 alt form
      send(10'b0101010101,      0, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0); // D10.2
      send(10'b0110000111,      0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1); // D0 with alt-7
      send(S_D21_5,             1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
      send(S_K28_5N,            0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
      send(S_D21_5,             0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
      send(S_ZERO,              0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd8);
      send(S_ZERO,              1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
      send(S_D21_5,             0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("gap_out_valid", 32'(out_valid), 32'd0);
         check("gap_data_hold", 32'(data_out), 32'hB5);
         check("gap_rd_hold", 32'(run_disparity_neg), 32'd1);
      end

      for (int i = 1; i <= 16; i++)
         send(S_ZERO, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, (i <= 3), (i >= 15) ? 4'd15 : CW'(i));

      @(negedge clk);
      symbol_in    = S_K28_5N;
      symbol_valid = 1'b1;
      reset        = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      symbol_valid = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_rdn", 32'(run_disparity_neg), 32'd1);
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      send(S_K28_5P,            0, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);

      idle();
      repeat (3) @(negedge clk);
      check("drain_pending", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
